reg_file: RTL
=============

# reg_file

Register file that feeds the ALU of the 8-bit single-cycle processor. It holds eight 8-bit general registers and writes one register per clock. Two combinational read ports drive the ALU operand buses: `out1` goes to data1, and `out2` goes to data2, which the Forward/ADD/AND/OR units consume. A sticky per-register "written" mask marks registers that have been written since reset, so software-visible reads of uninitialised registers can be flagged.

## Interface
Parameters:
- `DATA_W`, 8, register and data bus width.
- `ADDR_W`, 3, register address width; `REG_COUNT` = 2**ADDR_W = 8.
- `BYPASS`, 1, when 1, a read of the register being written this cycle returns `in_data`; when 0, it returns the stored value.

Ports:
- `clk`  in  1  single processor clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `write_en`  in  1  write strobe from the control unit.
- `in_addr`  in  ADDR_W  destination register (rd).
- `in_data`  in  DATA_W  write-back value (ALU result).
- `out1_addr`  in  ADDR_W  source register rs1.
- `out2_addr`  in  ADDR_W  source register rs2.
- `out1`  out  DATA_W  contents of rs1, to ALU data1.
- `out2`  out  DATA_W  contents of rs2, to ALU data2.
- `out1_valid`  out  1  rs1 has been written since reset.
- `out2_valid`  out  1  rs2 has been written since reset.
- `written`  out  REG_COUNT  sticky written mask; bit i means register i has been written.
- `write_count`  out  8  number of accepted writes since reset; saturates at 255.

## Operation
- **Storage:** `regs[0..7]`, each DATA_W bits. There is no hard-wired zero register.
- **Write:** on a rising `clk` edge with `reset_n`=1 and `write_en`=1:
  - `regs[in_addr]` <= `in_data`.
  - `written[in_addr]` <= 1.
  - `write_count` increments unless it is already 255.
- **Read:** purely combinational from address to data, with no clock involved.
  - `out1` = `regs[out1_addr]`; `out2` = `regs[out2_addr]`.
  - If BYPASS=1, `write_en`=1 and `outN_addr`==`in_addr`, then `outN` = `in_data` and `outN_valid` = 1.
- **Valid flags:** `outN_valid` = `written[outN_addr]`, OR'd with the bypass term when BYPASS=1.
- **Reset:** asynchronous. While `reset_n`=0:
  - all `regs` = 0, `written` = 0 and `write_count` = 0.
  - `out1`/`out2` read 0 and both valid flags are 0; bypass is disabled.
- **Boundary conditions:**
  - Both read ports on the same address return identical values.
  - A read and a write on the same address in one cycle follow BYPASS. The stored value updates at the edge either way.
  - Repeated writes to the same register keep its `written` bit at 1 and count every write.
  - `write_count` at 255 stays at 255; it does not wrap.
  - A write with `write_en`=0 changes nothing, whatever `in_addr`/`in_data` hold.
  - If reset is asserted mid-cycle, state clears immediately and the pending write is lost.
  - A rising edge that coincides with `reset_n` still low performs no write.
  - The first write is accepted on the first rising edge after `reset_n` goes high.

## Timing
- Write latency is 1 edge: the value is visible on a read port (with BYPASS=0) right after the writing edge.
- Read latency is 0 cycles and combinational. The read path must fit, together with the ALU, within one processor cycle.
- Reset values of all outputs are 0: `out1`, `out2`, `out1_valid`, `out2_valid`, `written`, `write_count`.
- There is no handshake and no stall. The control unit guarantees that `write_en`/`in_addr`/`in_data` are stable before the edge.

## Structure
- Shared package `cpu_pkg` holds `DATA_W`, `ADDR_W`, `REG_COUNT` and the `reg_addr_t`/`word_t` typedefs. The ALU units use the same package.
- A single sub-module, `reg_read_port`, is natural. It contains one address decode, the bypass mux and the valid flag. `reg_file` instantiates it twice.
- Storage, the written mask and the counter are all in `reg_file`.

## Test plan
- **Reset:** hold `reset_n`=0 for 2 cycles, then release. Required: all outputs are 0, and `out1_valid`=`out2_valid`=0 for every address.
- **Write then read:** write 25 to r3, 1 to r5 and 34 to r7 on consecutive edges, then set out1_addr=3 and out2_addr=7. Required:
  - `out1`=25 and `out2`=34, with both valid flags 1.
  - `written`=8'b1010_1000 and `write_count`=3.
- **Bypass:** with BYPASS=1, r2=10 stored, drive `write_en`=1, in_addr=2, in_data=99 and out2_addr=2. Required: `out2`=99 before the edge and 99 after it. With BYPASS=0, `out2`=10 before the edge and 99 after it.
- **Reset mid-operation:** after writes, pulse `reset_n` low between edges. Required: all registers read 0 immediately, `written`=0 and `write_count`=0. A write strobed on an edge while `reset_n`=0 has no effect.
- **Saturation:** perform 260 writes to r0. Required: `write_count`=255 and r0 holds the last value written.
- **Disabled write:** `write_en`=0 with in_addr=4 and in_data=77. Required: r4 stays 0, `written[4]`=0 and the count is unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared processor definitions: datapath widths, register address/word types
// and the saturating write counter helper used by the register file.
package cpu_pkg;

   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 3;
   localparam int REG_COUNT = 2**ADDR_W;
   localparam int CNT_W     = 8;

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0] word_t;
   typedef logic [CNT_W-1:0]  count_t;

   // Counter sticks at all-ones instead of wrapping.
   function automatic count_t sat_inc(input count_t c);
      return (c == '1) ? c : c + count_t'(1);
   endfunction

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port of the register file: address decode,
// same-cycle write bypass and the "written since reset" valid flag.
module reg_read_port #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int BYPASS = 1
) (
   input  logic [DATA_W-1:0]      regs [2**ADDR_W],
   input  logic [2**ADDR_W-1:0]   written,
   input  logic [ADDR_W-1:0]      rd_addr,
   input  logic                   wr_active,
   input  logic [ADDR_W-1:0]      wr_addr,
   input  logic [DATA_W-1:0]      wr_data,
   output logic [DATA_W-1:0]      rd_data,
   output logic                   rd_valid
);

   always_comb begin
      rd_data  = regs[rd_addr];
      rd_valid = written[rd_addr];
      // wr_active is already qualified by reset, so bypass is dead during reset.
      if ((BYPASS != 0) && wr_active && (wr_addr == rd_addr)) begin
         rd_data  = wr_data;
         rd_valid = 1'b1;
      end
   end

endmodule

// File: rtl/reg_file.sv
// Eight-entry register file feeding the ALU: one write per clock, two
// combinational read ports, sticky written mask and a saturating write count.
module reg_file
   import cpu_pkg::count_t, cpu_pkg::sat_inc;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int BYPASS = 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    write_en,
   input  logic [ADDR_W-1:0]       in_addr,
   input  logic [DATA_W-1:0]       in_data,
   input  logic [ADDR_W-1:0]       out1_addr,
   input  logic [ADDR_W-1:0]       out2_addr,
   output logic [DATA_W-1:0]       out1,
   output logic [DATA_W-1:0]       out2,
   output logic                    out1_valid,
   output logic                    out2_valid,
   output logic [2**ADDR_W-1:0]    written,
   output count_t                  write_count
);

   localparam int REG_COUNT = 2**ADDR_W;

   logic [DATA_W-1:0]    regs_q [REG_COUNT];
   logic [DATA_W-1:0]    regs_d [REG_COUNT];
   logic [REG_COUNT-1:0] written_q;
   logic [REG_COUNT-1:0] written_d;
   count_t               write_count_q;
   count_t               write_count_d;
   logic                 wr_active;

   always_comb begin
      regs_d        = regs_q;
      written_d     = written_q;
      write_count_d = write_count_q;
      if (write_en) begin
         regs_d[in_addr]    = in_data;
         written_d[in_addr] = 1'b1;
         write_count_d      = sat_inc(write_count_q);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         regs_q        <= '{default: '0};
         written_q     <= '0;
         write_count_q <= '0;
      end else begin
         regs_q        <= regs_d;
         written_q     <= written_d;
         write_count_q <= write_count_d;
      end
   end

   assign wr_active   = write_en & reset_n;
   assign written     = written_q;
   assign write_count = write_count_q;

   reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd1 (
      .regs      (regs_q),
      .written   (written_q),
      .rd_addr   (out1_addr),
      .wr_active (wr_active),
      .wr_addr   (in_addr),
      .wr_data   (in_data),
      .rd_data   (out1),
      .rd_valid  (out1_valid)
   );

   reg_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd2 (
      .regs      (regs_q),
      .written   (written_q),
      .rd_addr   (out2_addr),
      .wr_active (wr_active),
      .wr_addr   (in_addr),
      .wr_data   (in_data),
      .rd_data   (out2),
      .rd_valid  (out2_valid)
   );

endmodule
